// File: rtl/lsio_rst_ctrl.sv
// Purpose: system reset sequencer. It takes an error-unit request and a debounced button and drives staged peripheral/core resets, with a sticky cause and count.
// Latency: periph_rstn_o releases HOLD_CYCLES edges after the sequence starts, and sys_rstn_o STAGGER_CYCLES edges later. A button press acts DEBOUNCE_CYCLES+2 edges after the first low sample.
// Backpressure: none. req_reset_i is a level that is only honoured in RUN, and the core reset clears it at its source.
module lsio_rst_ctrl #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGGER_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       req_reset_i,
    input  logic       btn_rstn_i,
    output logic       periph_rstn_o,
    output logic       sys_rstn_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] rst_count_o
);

    // One sequence counter covers both the hold and the stagger phases.
    // It is sized for the longer of the two, so it never wraps.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_ERR = 2'd1;
    localparam logic [1:0] CAUSE_BTN = 2'd2;

    typedef enum logic [1:0] {
        ST_ASSERT     = 2'd0,
        ST_REL_PERIPH = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    // Button path state
    logic           btn_sync1_q;
    logic           btn_sync2_q;
    logic [DBW-1:0] db_cnt_q;
    logic [DBW-1:0] db_cnt_d;
    logic           pressed_q;
    logic           pressed_d;

    // Sequencer state
    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           periph_q;
    logic           periph_d;
    logic           sys_q;
    logic           sys_d;
    logic [1:0]     cause_q;
    logic [1:0]     cause_d;
    logic [7:0]     count_q;
    logic [7:0]     count_d;

    // Debounce: count consecutive low synced samples, saturating at DB_MAX.
    // Any high sample drops the press immediately.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        if (btn_sync2_q) begin
            db_cnt_d  = '0;
            pressed_d = 1'b0;
        end else begin
            if (db_cnt_q != DB_MAX) begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
            pressed_d = (db_cnt_d == DB_MAX);
        end
    end

    // Button synchronizer and debounce flops.
    // The synchronizer resets to the released (high) level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            btn_sync1_q <= 1'b1;
            btn_sync2_q <= 1'b1;
            db_cnt_q    <= '0;
            pressed_q   <= 1'b0;
        end else begin
            btn_sync1_q <= btn_rstn_i;
            btn_sync2_q <= btn_sync1_q;
            db_cnt_q    <= db_cnt_d;
            pressed_q   <= pressed_d;
        end
    end

    // Sequencer next state.
    // A press restarts the sequence from any state.
    // Only RUN can start a new recorded reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        sys_d    = sys_q;
        cause_d  = cause_q;
        count_d  = count_q;
        case (state_q)
            ST_ASSERT: begin
                periph_d = 1'b0;
                sys_d    = 1'b0;
                if (pressed_q) begin
                    // Hold the sequence at its start while the button is held.
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = ST_REL_PERIPH;
                    periph_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REL_PERIPH: begin
                if (pressed_q) begin
                    // Restart: cause and count stay as they are.
                    state_d  = ST_ASSERT;
                    periph_d = 1'b0;
                    sys_d    = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q == STAG_LAST) begin
                    state_d = ST_RUN;
                    sys_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (pressed_q || req_reset_i) begin
                    // The button wins when both arrive in the same cycle.
                    state_d  = ST_ASSERT;
                    periph_d = 1'b0;
                    sys_d    = 1'b0;
                    cnt_d    = '0;
                    cause_d  = pressed_q ? CAUSE_BTN : CAUSE_ERR;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_ASSERT;
                periph_d = 1'b0;
                sys_d    = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // Sequencer flops. Power-on reset also clears the sticky cause and count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            sys_q    <= 1'b0;
            cause_q  <= CAUSE_POR;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            sys_q    <= sys_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign periph_rstn_o = periph_q;
    assign sys_rstn_o    = sys_q;
    assign rst_cause_o   = cause_q;
    assign rst_count_o   = count_q;

endmodule

// File: tb/tb_lsio_rst_ctrl.sv
// Purpose: self-checking bench for lsio_rst_ctrl with HOLD=8, STAGGER=4, DEBOUNCE=4.
// Latency: outputs are compared against the model 1 time unit after every rising edge.
// Backpressure: not applicable; all stimulus is directed, and inputs change on falling edges.
module tb_lsio_rst_ctrl;

    localparam int H = 8;
    localparam int S = 4;
    localparam int D = 4;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b0;
    logic       req    = 1'b0;
    logic       btn    = 1'b1;
    logic       periph;
    logic       sys;
    logic [1:0] cause;
    logic [7:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lsio_rst_ctrl #(
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_reset_i  (req),
        .btn_rstn_i   (btn),
        .periph_rstn_o(periph),
        .sys_rstn_o   (sys),
        .rst_cause_o  (cause),
        .rst_count_o  (count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model.
    // m_t counts sequence edges elapsed since the last restart, saturating once
    // both resets are released. A press is inferred from the run length of low
    // button samples: it is visible to the sequencer three edges after the
    // D-th consecutive low sample.
    int m_t     = 0;
    int m_cause = 0;
    int m_count = 0;
    int lr1 = 0, lr2 = 0, lr3 = 0;
    bit m_pr;
    int m_nlr;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_t = 0; m_cause = 0; m_count = 0;
            lr1 = 0; lr2 = 0; lr3 = 0;
        end else begin
            m_pr = (lr3 >= D);
            if (m_t < H + S) begin
                if (m_pr) m_t = 0;
                else      m_t = m_t + 1;
            end else if (m_pr || req) begin
                m_t     = 0;
                m_cause = m_pr ? 2 : 1;
                if (m_count < 255) m_count = m_count + 1;
            end
            m_nlr = btn ? 0 : ((lr1 < 1000) ? lr1 + 1 : lr1);
            lr3 = lr2; lr2 = lr1; lr1 = m_nlr;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        check("m_periph", int'(periph), (m_t >= H) ? 1 : 0);
        check("m_sys",    int'(sys),    (m_t >= H + S) ? 1 : 0);
        check("m_cause",  int'(cause),  m_cause);
        check("m_count",  int'(count),  m_count);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Power-on reset state
        wait_n(3);
        check("por_periph", int'(periph), 0);
        check("por_sys",    int'(sys),    0);
        check("por_cause",  int'(cause),  0);
        check("por_count",  int'(count),  0);

        // 1: POR release timing 8/12
        rstn = 1'b1;
        wait_n(7);  check("por_e7_periph",  int'(periph), 0);
        wait_n(1);  check("por_e8_periph",  int'(periph), 1);
                    check("por_e8_sys",     int'(sys),    0);
        wait_n(3);  check("por_e11_sys",    int'(sys),    0);
        wait_n(1);  check("por_e12_sys",    int'(sys),    1);
                    check("por_rel_cause",  int'(cause),  0);
                    check("por_rel_count",  int'(count),  0);

        // 2: one-cycle error request in RUN
        req = 1'b1; wait_n(1); req = 1'b0;
        check("err_periph", int'(periph), 0);
        check("err_sys",    int'(sys),    0);
        check("err_cause",  int'(cause),  1);
        check("err_count",  int'(count),  1);
        wait_n(7);  check("err_e7_periph", int'(periph), 0);
        wait_n(1);  check("err_e8_periph", int'(periph), 1);
        wait_n(3);  check("err_e11_sys",   int'(sys),    0);
        wait_n(1);  check("err_e12_sys",   int'(sys),    1);

        // 3: a short glitch is rejected; a 10-cycle press resets; a held button
        // keeps the peripherals in reset
        btn = 1'b0; wait_n(3); btn = 1'b1; wait_n(10);
        check("glitch_sys",   int'(sys),   1);
        check("glitch_count", int'(count), 1);
        btn = 1'b0; wait_n(10); btn = 1'b1;
        check("btn10_periph", int'(periph), 0);
        check("btn10_cause",  int'(cause),  2);
        check("btn10_count",  int'(count),  2);
        wait_n(20); check("btn10_rel_sys", int'(sys), 1);
        btn = 1'b0; wait_n(50);
        check("held_periph", int'(periph), 0);
        check("held_count",  int'(count),  3);
        btn = 1'b1;
        wait_n(10); check("held_rel9_periph",  int'(periph), 0);
        wait_n(1);  check("held_rel10_periph", int'(periph), 1);
        wait_n(4);  check("held_rel14_sys",    int'(sys),    1);

        // 4: press and request in the same RUN cycle; request ignored in ASSERT
        btn = 1'b0; wait_n(6); req = 1'b1; btn = 1'b1; wait_n(1); req = 1'b0;
        check("both_periph", int'(periph), 0);
        check("both_cause",  int'(cause),  2);
        check("both_count",  int'(count),  4);
        req = 1'b1; wait_n(3); req = 1'b0;
        check("assert_req_count", int'(count), 4);
        check("assert_req_cause", int'(cause), 2);
        wait_n(30);
        check("assert_req_sys",   int'(sys),   1);
        check("assert_req_count2", int'(count), 4);

        // 5: press lands in REL_PERIPH
        req = 1'b1; wait_n(1); req = 1'b0;
        wait_n(3); btn = 1'b0; wait_n(4); btn = 1'b1;
        wait_n(2); check("rel_pre_periph", int'(periph), 1);
                   check("rel_pre_sys",    int'(sys),    0);
        wait_n(1); check("rel_drop_periph", int'(periph), 0);
                   check("rel_drop_cause",  int'(cause),  1);
                   check("rel_drop_count",  int'(count),  5);
        wait_n(7); check("rel_e7_periph",  int'(periph), 0);
        wait_n(1); check("rel_e8_periph",  int'(periph), 1);
        wait_n(4); check("rel_e12_sys",    int'(sys),    1);

        // 6: counter saturation, then an asynchronous power-on reset
        for (int i = 0; i < 300; i++) begin
            req = 1'b1; wait_n(1); req = 1'b0; wait_n(12);
        end
        check("sat_count", int'(count), 255);
        check("sat_cause", int'(cause), 1);
        req = 1'b1; wait_n(1); req = 1'b0; wait_n(3);
        #2 rstn = 1'b0;
        #1;
        check("async_periph", int'(periph), 0);
        check("async_sys",    int'(sys),    0);
        check("async_cause",  int'(cause),  0);
        check("async_count",  int'(count),  0);
        wait_n(2); rstn = 1'b1;
        wait_n(12);
        check("repor_sys",   int'(sys),   1);
        check("repor_count", int'(count), 0);
        wait_n(1);
        #2 rstn = 1'b0;
        #1;
        check("async_run_periph", int'(periph), 0);
        check("async_run_sys",    int'(sys),    0);
        wait_n(2); rstn = 1'b1;
        wait_n(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
